alu_instr_sequencer: RTL and testbench
======================================

# alu_instr_sequencer

Hardwired control sequencer for the Mini-SRC datapath. It drives the `Datapath` control strobes through fetch (T0–T2) and execute (T3–T6) for register-register ALU, multiply and divide instructions. It reads the instruction word back from the datapath IR, decodes opcode and register fields, and replaces the hand-sequenced control currently used in bring-up.

## Interface
- `OP_MUL`, default 5'b01111: opcode using the HI/LO writeback path.
- `OP_DIV`, default 5'b10000: opcode using the HI/LO writeback path.
- `OP_NOP`, default 5'b11010: fetch only, no execute.
- `OP_HALT`, default 5'b11011: stop sequencing.
- `clock` in 1: single clock, rising edge.
- `clear` in 1: synchronous, active-high reset.
- `run` in 1: level; permits fetch of the next instruction.
- `mem_ready` in 1: memory data valid on `Mdatain` this cycle.
- `ir` in 32: datapath IR contents.
- `PCout`, `IncPC`, `PCin`, `MARin`, `Read`, `MDRin`, `MDRout`, `IRin`, `Yin` out 1 each: datapath strobes.
- `Zlowin`, `Zhighin`, `Zlowout`, `Zhighout`, `HIin`, `LOin` out 1 each: datapath strobes.
- `R0_15_in`, `R0_15_out` out 16 each: one-hot register-file write and read selects.
- `opcode` out 5: ALU operation select.
- `instr_done` out 1: one-cycle pulse on the last cycle of each instruction.
- `halted` out 1: high while in HALT.
- `illegal` out 1: sticky; set on an undefined opcode.

## Operation
- Field decode: op = `ir[31:27]`, ra = `ir[26:23]`, rb = `ir[22:19]`, rc = `ir[18:15]`.
  - Example: 32'h28918000 decodes to op 00101, ra 1, rb 2, rc 3.
- Instruction classes:
  - ALU: op 00000–01110 except `OP_MUL`.
  - MULDIV: `OP_MUL`, `OP_DIV`.
  - NOP, HALT.
  - Illegal: all other opcodes.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT. State is registered; all outputs are decoded combinationally from state and `ir` (Moore).
- Per-state outputs (every signal not listed is 0):
  - IDLE: nothing asserted. Go to T0 when `run`=1.
  - T0: `PCout`, `MARin`, `IncPC`, `Zlowin`. Go to T1.
  - T1: `Zlowout`, `PCin`, `Read`, `MDRin`. Hold in T1 while `mem_ready`=0; go to T2 on `mem_ready`=1. Re-asserting `PCin` while holding is harmless because Z is unchanged.
  - T2: `MDRout`, `IRin`. Go to T3.
  - T3: decode of `ir` (valid from this cycle).
    - HALT: no strobes; go to HALT.
    - NOP or illegal: no strobes, `instr_done`=1; go to T0 if `run`, else IDLE. Illegal also sets `illegal`.
    - ALU or MULDIV: `R0_15_out`=onehot(rb), `Yin`; go to T4.
  - T4: `R0_15_out`=onehot(rc), `opcode`=op, `Zlowin`; MULDIV also asserts `Zhighin`. Go to T5.
  - T5:
    - ALU: `Zlowout`, `R0_15_in`=onehot(ra), `instr_done`; go to T0 if `run`, else IDLE.
    - MULDIV: `Zlowout`, `LOin`; go to T6.
  - T6: `Zhighout`, `HIin`, `instr_done`; go to T0 if `run`, else IDLE.
  - HALT: `halted`=1. Stay until `clear`; `run` is ignored.
- `opcode` is 5'b00000 outside T4. T0 relies on the ALU's PC+1 path via `IncPC`, not on `opcode`.
- At most one bit of `R0_15_in` and of `R0_15_out` is high in any cycle. Both are zero outside T3/T4/T5.
- ra = 0 is allowed; R0 write handling belongs to the register file.

## Timing
- `clear`=1 at a rising edge: next state IDLE, `illegal`=0. All outputs are 0 in the following cycle. This applies from any state, including mid-instruction and HALT.
- Strobes are valid for the whole cycle of their state; the datapath samples them at the closing edge.
- Fetch latency with zero wait: 3 cycles (T0–T2).
- Total cycles per instruction, zero wait: ALU 6, MULDIV 7, NOP/illegal 4, HALT reached after 4.
- Each cycle `mem_ready` is low in T1 adds one cycle.
- `run` is sampled only at instruction boundaries (IDLE and the final execute state). Dropping `run` mid-instruction finishes the current instruction.
- `instr_done` is high exactly one cycle per completed instruction and never in HALT.
- Back-to-back: with `run` held high, the final state of one instruction is immediately followed by T0 of the next; there is no idle cycle.

## Test plan
- Reset and idle: `clear`=1 for 2 cycles, then `run`=0 -> every output 0 and state IDLE for 10 cycles.
- ALU instruction: `ir`=32'h28918000, `run`=1, `mem_ready`=1 -> the strobes above in 6 cycles, with:
  - T3: `R0_15_out`=16'h0004.
  - T4: `R0_15_out`=16'h0008, `opcode`=5'b00101.
  - T5: `R0_15_in`=16'h0002, `instr_done`=1.
  - Next cycle is T0.
- Memory wait: hold `mem_ready`=0 for 3 cycles in T1 -> `Read`/`MDRin` stay high for 4 cycles; `IRin` appears only after `mem_ready`.
- MUL instruction: op=`OP_MUL`, rb=4, rc=5 ->
  - T4: `Zlowin`=`Zhighin`=1.
  - T5: `LOin` with `Zlowout`.
  - T6: `HIin` with `Zhighout`, `instr_done`.
  - No `R0_15_in` bit is set at any point.
- HALT and illegal:
  - op 11111 -> `illegal`=1 after T3, then fetch resumes.
  - Next instruction `OP_HALT` -> `halted`=1 and stays with `run`=1.
  - `clear` -> `halted`=0, `illegal`=0.
- Reset mid-op: assert `clear` during T4 -> next cycle IDLE with all outputs 0. With `run`=1, T0 is reached one cycle after `clear` deasserts.

Source files
------------

// File: rtl/alu_instr_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_instr_sequencer_if
//
// Bundle between the Mini-SRC hardwired control sequencer and the datapath.
//
//   run, mem_ready, ir      : datapath/system -> sequencer
//                             run       level, permits fetch of the next instr
//                             mem_ready memory data valid on Mdatain
//                             ir        current contents of the datapath IR
//   PCout .. LOin           : sequencer -> datapath, single-bit control strobes
//   R0_15_in / R0_15_out    : sequencer -> datapath, one-hot register selects
//   opcode                  : sequencer -> datapath, ALU operation select
//   instr_done, halted,
//   illegal                 : sequencer -> system, status
//
// The master modport is the sequencer's view; the slave modport is the view
// of whatever drives run/mem_ready/ir and consumes the strobes.
// ---------------------------------------------------------------------------
interface alu_instr_sequencer_if;

    logic        run;
    logic        mem_ready;
    logic [31:0] ir;

    logic        PCout;
    logic        IncPC;
    logic        PCin;
    logic        MARin;
    logic        Read;
    logic        MDRin;
    logic        MDRout;
    logic        IRin;
    logic        Yin;
    logic        Zlowin;
    logic        Zhighin;
    logic        Zlowout;
    logic        Zhighout;
    logic        HIin;
    logic        LOin;
    logic [15:0] R0_15_in;
    logic [15:0] R0_15_out;
    logic [4:0]  opcode;
    logic        instr_done;
    logic        halted;
    logic        illegal;

    modport master (
        input  run, mem_ready, ir,
        output PCout, IncPC, PCin, MARin, Read, MDRin, MDRout, IRin, Yin,
        output Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin,
        output R0_15_in, R0_15_out, opcode,
        output instr_done, halted, illegal
    );

    modport slave (
        output run, mem_ready, ir,
        input  PCout, IncPC, PCin, MARin, Read, MDRin, MDRout, IRin, Yin,
        input  Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin,
        input  R0_15_in, R0_15_out, opcode,
        input  instr_done, halted, illegal
    );

endinterface

// File: rtl/alu_instr_sequencer.sv
// ---------------------------------------------------------------------------
// alu_instr_sequencer
//
// Hardwired control sequencer for the Mini-SRC datapath. Steps through the
// fetch phase (T0-T2) and the execute phase (T3-T6) for register-register
// ALU, multiply and divide instructions, decoding the instruction word read
// back from the datapath IR.
//
// Ports:
//   clock  : single clock, rising edge
//   clear  : synchronous active-high reset (state -> IDLE, illegal -> 0)
//   bus    : alu_instr_sequencer_if.master (run/mem_ready/ir in, strobes
//            and status out)
//
// Parameters:
//   OP_MUL, OP_DIV : opcodes that write back through HI/LO
//   OP_NOP         : fetch only, no execute
//   OP_HALT        : stop sequencing until clear
//
// Outputs are Moore: decoded from the registered state plus the IR fields,
// so every strobe is stable for the whole cycle of its state.
// ---------------------------------------------------------------------------
module alu_instr_sequencer #(
    parameter logic [4:0] OP_MUL  = 5'b01111,
    parameter logic [4:0] OP_DIV  = 5'b10000,
    parameter logic [4:0] OP_NOP  = 5'b11010,
    parameter logic [4:0] OP_HALT = 5'b11011
) (
    input  logic                        clock,
    input  logic                        clear,
    alu_instr_sequencer_if.master       bus
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALT
    } state_t;

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;

    // Instruction fields; only meaningful from T3 onwards, once IR is loaded.
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       is_halt, is_nop, is_muldiv, is_alu, is_illegal;

    // The low 15 bits of the IR (constant/unused field) are not needed here.
    logic unused_ir_bits;

    assign op  = bus.ir[31:27];
    assign ra  = bus.ir[26:23];
    assign rb  = bus.ir[22:19];
    assign rc  = bus.ir[18:15];
    assign unused_ir_bits = ^bus.ir[14:0];

    // Class decode. HALT and NOP are checked first so that an unusual
    // parameter choice overlapping the ALU range still behaves predictably.
    assign is_halt    = (op == OP_HALT);
    assign is_nop     = (op == OP_NOP) && !is_halt;
    assign is_muldiv  = ((op == OP_MUL) || (op == OP_DIV)) && !is_halt && !is_nop;
    assign is_alu     = (op <= 5'b01110) && !is_muldiv && !is_halt && !is_nop;
    assign is_illegal = !(is_halt || is_nop || is_muldiv || is_alu);

    function automatic logic [15:0] onehot16(input logic [3:0] idx);
        logic [15:0] one;
        one      = 16'h0001;
        onehot16 = one << idx;
    endfunction

    // Next-state and output decode. Every output defaults to 0 so that each
    // state only lists what it asserts. The final execute state of each class
    // is the only place besides IDLE where run is looked at.
    always_comb begin
        state_d        = state_q;
        illegal_d      = illegal_q;

        bus.PCout      = 1'b0;
        bus.IncPC      = 1'b0;
        bus.PCin       = 1'b0;
        bus.MARin      = 1'b0;
        bus.Read       = 1'b0;
        bus.MDRin      = 1'b0;
        bus.MDRout     = 1'b0;
        bus.IRin       = 1'b0;
        bus.Yin        = 1'b0;
        bus.Zlowin     = 1'b0;
        bus.Zhighin    = 1'b0;
        bus.Zlowout    = 1'b0;
        bus.Zhighout   = 1'b0;
        bus.HIin       = 1'b0;
        bus.LOin       = 1'b0;
        bus.R0_15_in   = 16'h0000;
        bus.R0_15_out  = 16'h0000;
        bus.opcode     = 5'b00000;
        bus.instr_done = 1'b0;
        bus.halted     = 1'b0;
        bus.illegal    = illegal_q;

        case (state_q)
            S_IDLE: begin
                if (bus.run) begin
                    state_d = S_T0;
                end
            end

            // PC -> MAR, and PC+1 captured into Z via the IncPC path.
            S_T0: begin
                bus.PCout  = 1'b1;
                bus.MARin  = 1'b1;
                bus.IncPC  = 1'b1;
                bus.Zlowin = 1'b1;
                state_d    = S_T1;
            end

            // Z -> PC while memory is read into MDR. Holding here keeps PCin
            // high, which is harmless because Z does not change.
            S_T1: begin
                bus.Zlowout = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_T2;
                end
            end

            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                state_d    = S_T3;
            end

            // IR is valid from here on; branch on instruction class.
            S_T3: begin
                if (is_halt) begin
                    state_d = S_HALT;
                end else if (is_alu || is_muldiv) begin
                    bus.R0_15_out = onehot16(rb);
                    bus.Yin       = 1'b1;
                    state_d       = S_T4;
                end else begin
                    bus.instr_done = 1'b1;
                    if (is_illegal) begin
                        illegal_d = 1'b1;
                    end
                    state_d = bus.run ? S_T0 : S_IDLE;
                end
            end

            S_T4: begin
                bus.R0_15_out = onehot16(rc);
                bus.opcode    = op;
                bus.Zlowin    = 1'b1;
                bus.Zhighin   = is_muldiv;
                state_d       = S_T5;
            end

            S_T5: begin
                bus.Zlowout = 1'b1;
                if (is_muldiv) begin
                    bus.LOin = 1'b1;
                    state_d  = S_T6;
                end else begin
                    bus.R0_15_in   = onehot16(ra);
                    bus.instr_done = 1'b1;
                    state_d        = bus.run ? S_T0 : S_IDLE;
                end
            end

            S_T6: begin
                bus.Zhighout   = 1'b1;
                bus.HIin       = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = bus.run ? S_T0 : S_IDLE;
            end

            // Only clear leaves HALT.
            S_HALT: begin
                bus.halted = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and the sticky illegal flag; clear overrides everything,
    // including a same-cycle illegal decode in T3.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_instr_sequencer
//
// Drives instructions into alu_instr_sequencer one cycle at a time. For each
// instruction the expected strobe pattern of every cycle is built from the
// instruction's class (fetch, then the class's execute steps) and pushed into
// a scoreboard queue; an independent monitor pops one entry per observed
// cycle and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_alu_instr_sequencer;

    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef struct packed {
        logic        pc_out;
        logic        inc_pc;
        logic        pc_in;
        logic        mar_in;
        logic        read;
        logic        mdr_in;
        logic        mdr_out;
        logic        ir_in;
        logic        y_in;
        logic        zlow_in;
        logic        zhigh_in;
        logic        zlow_out;
        logic        zhigh_out;
        logic        hi_in;
        logic        lo_in;
        logic [15:0] r_in;
        logic [15:0] r_out;
        logic [4:0]  opcode;
        logic        instr_done;
        logic        halted;
        logic        illegal;
    } out_t;

    logic clock = 1'b0;
    logic clear;

    alu_instr_sequencer_if bus ();

    alu_instr_sequencer dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    out_t  exp_q[$];
    string tag_q[$];
    int    checks      = 0;
    int    errors      = 0;
    int    instr_count = 0;
    logic  exp_illegal = 1'b0;
    logic  in_idle     = 1'b1;

    function automatic out_t sampleDut();
        out_t a;
        a.pc_out     = bus.PCout;
        a.inc_pc     = bus.IncPC;
        a.pc_in      = bus.PCin;
        a.mar_in     = bus.MARin;
        a.read       = bus.Read;
        a.mdr_in     = bus.MDRin;
        a.mdr_out    = bus.MDRout;
        a.ir_in      = bus.IRin;
        a.y_in       = bus.Yin;
        a.zlow_in    = bus.Zlowin;
        a.zhigh_in   = bus.Zhighin;
        a.zlow_out   = bus.Zlowout;
        a.zhigh_out  = bus.Zhighout;
        a.hi_in      = bus.HIin;
        a.lo_in      = bus.LOin;
        a.r_in       = bus.R0_15_in;
        a.r_out      = bus.R0_15_out;
        a.opcode     = bus.opcode;
        a.instr_done = bus.instr_done;
        a.halted     = bus.halted;
        a.illegal    = bus.illegal;
        return a;
    endfunction

    // Compare one observed cycle against its scoreboard entry.
    task automatic checkOutput(input out_t act, input out_t exp, input string tag);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %h required %h", tag, act, exp);
        end
    endtask

    // Monitor: samples mid-cycle, away from the active edge.
    initial begin
        out_t  e;
        string t;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                checkOutput(sampleDut(), e, t);
            end
        end
    end

    // One cycle of stimulus plus its expected outputs.
    task automatic driveCycle(input logic run_v, input logic mem_v, input logic clr_v,
                              input logic [31:0] ir_v, input out_t exp, input string tag);
        @(posedge clock);
        #1;
        clear         = clr_v;
        bus.run       = run_v;
        bus.mem_ready = mem_v;
        bus.ir        = ir_v;
        exp.illegal   = exp_illegal;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    // Issue one instruction. waits = mem_ready-low cycles in the memory read
    // step, run_end = run level at the final cycle, clear_at = cycle index at
    // which clear is asserted (-1 for none), gap = idle cycles before run is
    // raised when starting from IDLE (-1 for random).
    task automatic applyStimulus(input logic [31:0] ir_v, input int waits, input logic run_end,
                                 input int clear_at, input int gap);
        out_t       seq[$];
        logic       mem_seq[$];
        string      name_seq[$];
        out_t       c;
        out_t       z;
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        logic       is_halt, is_nop, is_md, is_alu, is_ill, cleared, last;
        int         n;

        z  = '0;
        op = ir_v[31:27];
        ra = ir_v[26:23];
        rb = ir_v[22:19];
        rc = ir_v[18:15];
        is_halt = (op == OP_HALT);
        is_nop  = (op == OP_NOP);
        is_md   = (op == OP_MUL) || (op == OP_DIV);
        is_alu  = (op <= 5'd14) && !is_md;
        is_ill  = !(is_halt || is_nop || is_md || is_alu);
        instr_count++;

        if (in_idle) begin
            n = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            for (int i = 0; i < n; i++)
                driveCycle(1'b0, 1'($urandom_range(0, 1)), 1'b0, ir_v, z, "IDLE");
            driveCycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, ir_v, z, "IDLE run");
            in_idle = 1'b0;
        end

        // Fetch: PC to MAR with increment, memory read (with waits), IR load.
        c = z; c.pc_out = 1; c.mar_in = 1; c.inc_pc = 1; c.zlow_in = 1;
        seq.push_back(c); mem_seq.push_back(1'($urandom_range(0, 1))); name_seq.push_back("T0");
        for (int w = 0; w <= waits; w++) begin
            c = z; c.zlow_out = 1; c.pc_in = 1; c.read = 1; c.mdr_in = 1;
            seq.push_back(c); mem_seq.push_back(w == waits); name_seq.push_back("T1");
        end
        c = z; c.mdr_out = 1; c.ir_in = 1;
        seq.push_back(c); mem_seq.push_back(1'($urandom_range(0, 1))); name_seq.push_back("T2");

        // Execute by class.
        if (is_halt) begin
            seq.push_back(z); name_seq.push_back("T3 halt");
            mem_seq.push_back(1'($urandom_range(0, 1)));
        end else if (is_nop || is_ill) begin
            c = z; c.instr_done = 1;
            seq.push_back(c); name_seq.push_back("T3 nop/ill");
            mem_seq.push_back(1'($urandom_range(0, 1)));
        end else begin
            c = z; c.r_out[rb] = 1'b1; c.y_in = 1;
            seq.push_back(c); name_seq.push_back("T3");
            mem_seq.push_back(1'($urandom_range(0, 1)));
            c = z; c.r_out[rc] = 1'b1; c.opcode = op; c.zlow_in = 1; c.zhigh_in = is_md;
            seq.push_back(c); name_seq.push_back("T4");
            mem_seq.push_back(1'($urandom_range(0, 1)));
            if (is_md) begin
                c = z; c.zlow_out = 1; c.lo_in = 1;
                seq.push_back(c); name_seq.push_back("T5 lo");
                mem_seq.push_back(1'($urandom_range(0, 1)));
                c = z; c.zhigh_out = 1; c.hi_in = 1; c.instr_done = 1;
                seq.push_back(c); name_seq.push_back("T6 hi");
                mem_seq.push_back(1'($urandom_range(0, 1)));
            end else begin
                c = z; c.zlow_out = 1; c.r_in[ra] = 1'b1; c.instr_done = 1;
                seq.push_back(c); name_seq.push_back("T5 wb");
                mem_seq.push_back(1'($urandom_range(0, 1)));
            end
        end

        // run toggles freely mid-instruction; only its final-cycle value counts.
        cleared = 1'b0;
        for (int i = 0; i < seq.size(); i++) begin
            last = (i == seq.size() - 1);
            driveCycle(last ? run_end : 1'($urandom_range(0, 1)), mem_seq[i], (i == clear_at),
                       ir_v, seq[i], $sformatf("instr%0d %s", instr_count, name_seq[i]));
            if (i == clear_at) begin
                cleared = 1'b1;
                break;
            end
        end

        if (cleared) begin
            exp_illegal = 1'b0;
            in_idle     = 1'b1;
        end else if (is_halt) begin
            c = z; c.halted = 1;
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++)
                driveCycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, ir_v, c,
                           $sformatf("instr%0d HALT", instr_count));
            driveCycle(1'b1, 1'b1, 1'b1, ir_v, c, $sformatf("instr%0d HALT clear", instr_count));
            exp_illegal = 1'b0;
            in_idle     = 1'b1;
        end else begin
            if (is_ill) exp_illegal = 1'b1;
            in_idle = !run_end;
        end
    endtask

    function automatic logic [31:0] randInstr();
        logic [4:0] op;
        int         r;
        r = $urandom_range(0, 99);
        if (r < 50)      op = 5'($urandom_range(0, 14));
        else if (r < 70) op = (r < 60) ? OP_MUL : OP_DIV;
        else if (r < 80) op = OP_NOP;
        else if (r < 94) begin
            op = 5'($urandom_range(17, 31));
            if (op == OP_NOP || op == OP_HALT) op = 5'b11111;
        end else         op = OP_HALT;
        return {op, 27'($urandom)};
    endfunction

    initial begin
        out_t z;
        int   t;
        z             = '0;
        clear         = 1'b1;
        bus.run       = 1'b0;
        bus.mem_ready = 1'b0;
        bus.ir        = 32'h0;
        repeat (2) @(posedge clock);

        // Reset and idle: run low keeps everything quiet.
        for (int i = 0; i < 10; i++)
            driveCycle(1'b0, 1'b1, 1'b0, 32'h0, z, "reset idle");
        in_idle = 1'b1;

        // ALU r1 <- r2 op r3, back to back with a memory-wait version.
        applyStimulus(32'h28918000, 0, 1'b1, -1, 0);
        applyStimulus(32'h28918000, 3, 1'b1, -1, 0);
        // MUL rb=4 rc=5, then finish with run low.
        applyStimulus({OP_MUL, 4'd6, 4'd4, 4'd5, 15'h0}, 0, 1'b0, -1, 0);
        // Illegal opcode, then HALT (cleared inside), fetch resumes after.
        applyStimulus({5'b11111, 27'h1234567}, 1, 1'b1, -1, 0);
        applyStimulus({OP_HALT, 27'h0}, 0, 1'b1, -1, 0);
        // Clear during T4 of an ALU instruction.
        applyStimulus(32'h28918000, 0, 1'b1, 4, 0);
        applyStimulus({OP_DIV, 4'd15, 4'd0, 4'd15, 15'h7fff}, 2, 1'b1, -1, 0);
        applyStimulus({OP_NOP, 27'h0}, 0, 1'b0, -1, 1);

        for (int k = 0; k < 300; k++) begin
            applyStimulus(randInstr(), int'($urandom_range(0, 3)),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 7)) : -1, -1);
        end

        t = 0;
        while (exp_q.size() > 0 && t < 20) begin
            @(negedge clock);
            t++;
        end
        @(posedge clock);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: actual %0d pending entries required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
